// File: rtl/cond_exec_ctrl.sv
// Conditional-execution controller: tracks the {c,v,n,z} status register and decodes condition
// pass. It stalls on flag hazards, flushes after taken branches and counts stalls and flushes.
module cond_exec_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,  // legal 1..7
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             id_valid,
  input  logic [3:0]       id_cond,
  input  logic             id_is_branch,
  input  logic             ex_flags_we,
  input  logic [3:0]       ex_flags,
  output logic [3:0]       status_q,
  output logic             id_exec,
  output logic             id_stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {StRun, StHaz, StFlush} state_e;

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [3:0]       status_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             pass, cond_al, hazard, flush_start;
  logic             c, v, n, z;

  assign c = status_q[3];
  assign v = status_q[2];
  assign n = status_q[1];
  assign z = status_q[0];

  always_comb begin
    pass = 1'b0;
    unique case (id_cond)
      4'h0: pass = z;
      4'h1: pass = ~z;
      4'h2: pass = c;
      4'h3: pass = ~c;
      4'h4: pass = n;
      4'h5: pass = ~n;
      4'h6: pass = v;
      4'h7: pass = ~v;
      4'h8: pass = c & ~z;
      4'h9: pass = ~c | z;
      4'ha: pass = (n == v);
      4'hb: pass = (n != v);
      4'hc: pass = ~z & (n == v);
      4'hd: pass = z | (n != v);
      4'he, 4'hf: pass = 1'b1;
    endcase
  end

  // Always-execute conditions never depend on flags, so they cannot hazard.
  assign cond_al  = (id_cond[3:1] == 3'b111);
  assign hazard   = (state_q == StRun) & id_valid & ex_flags_we & ~cond_al;
  assign id_stall = hazard & ~freeze;
  assign id_exec  = id_valid & pass & ~hazard & (state_q != StFlush) & ~freeze;
  assign flush    = (state_q == StFlush);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      StRun: begin
        if (freeze) begin
          state_d = StRun;
        end else if (hazard) begin
          state_d = StHaz;
        end else if (id_exec && id_is_branch) begin
          state_d = StFlush;
          fcnt_d  = 3'(FLUSH_CYCLES);
        end
      end
      StHaz: begin
        if (!freeze) begin
          if (id_exec && id_is_branch) begin
            state_d = StFlush;
            fcnt_d  = 3'(FLUSH_CYCLES);
          end else begin
            state_d = StRun;
          end
        end
      end
      StFlush: begin
        if (!freeze) begin
          if (fcnt_q > 3'd1) begin
            fcnt_d = fcnt_q - 3'd1;
          end else begin
            state_d = StRun;
            fcnt_d  = 3'd0;
          end
        end
      end
      default: begin
        state_d = StRun;
        fcnt_d  = 3'd0;
      end
    endcase
  end

  assign flush_start = (state_d == StFlush) && (state_q != StFlush);

  always_comb begin
    status_d    = status_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ex_flags_we && !freeze) begin
      status_d = ex_flags;
    end
    // id_stall and flush_start are already gated by freeze, so counters hold when frozen.
    if (id_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (flush_start && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      fcnt_q      <= 3'd0;
      status_q    <= 4'b0000;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      status_q    <= status_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Directed bench for cond_exec_ctrl with FLUSH_CYCLES=2 and 3-bit counters so that
// saturation is reachable.
module tb_cond_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       freeze = 1'b0;
  logic       id_valid = 1'b0;
  logic [3:0] id_cond = 4'h0;
  logic       id_is_branch = 1'b0;
  logic       ex_flags_we = 1'b0;
  logic [3:0] ex_flags = 4'h0;
  logic [3:0] status_q;
  logic       id_exec, id_stall, flush;
  logic [2:0] stall_cnt, flush_cnt;

  int n_total = 0;
  int n_bad   = 0;

  cond_exec_ctrl #(.FLUSH_CYCLES(2), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .id_valid     (id_valid),
    .id_cond      (id_cond),
    .id_is_branch (id_is_branch),
    .ex_flags_we  (ex_flags_we),
    .ex_flags     (ex_flags),
    .status_q     (status_q),
    .id_exec      (id_exec),
    .id_stall     (id_stall),
    .flush        (flush),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #20 clk = ~clk;

  function automatic logic exp_pass(input logic [3:0] cond, input logic [3:0] f);
    logic fc, fv, fn, fz;
    fc = f[3]; fv = f[2]; fn = f[1]; fz = f[0];
    case (cond)
      4'h0: return fz;
      4'h1: return !fz;
      4'h2: return fc;
      4'h3: return !fc;
      4'h4: return fn;
      4'h5: return !fn;
      4'h6: return fv;
      4'h7: return !fv;
      4'h8: return fc && !fz;
      4'h9: return !fc || fz;
      4'ha: return fn == fv;
      4'hb: return fn != fv;
      4'hc: return !fz && (fn == fv);
      4'hd: return fz || (fn != fv);
      default: return 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] cond, input logic br,
                       input logic we, input logic [3:0] fl, input logic frz);
    id_valid = v; id_cond = cond; id_is_branch = br;
    ex_flags_we = we; ex_flags = fl; freeze = frz;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    #1;
    n_total++; if (status_q !== 4'b0000) begin n_bad++; $display("FAIL rst_status got=%b exp=0000", status_q); end
    n_total++; if (flush !== 1'b0) begin n_bad++; $display("FAIL rst_flush got=%b exp=0", flush); end
    n_total++; if (stall_cnt !== 3'd0 || flush_cnt !== 3'd0) begin n_bad++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    drive(1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    n_total++; if (id_exec !== 1'b0) begin n_bad++; $display("FAIL rst_exec_eq got=%b exp=0", id_exec); end
    drive(1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0);
    n_total++; if (id_exec !== 1'b1) begin n_bad++; $display("FAIL rst_exec_ne got=%b exp=1", id_exec); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_decode();
    do_reset();
    for (int s = 0; s < 16; s++) begin
      drive(1'b0, 4'h0, 1'b0, 1'b1, 4'(s), 1'b0);
      tick();
      drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
      n_total++; if (status_q !== 4'(s)) begin n_bad++; $display("FAIL dec_status got=%b exp=%b", status_q, 4'(s)); end
      for (int k = 0; k < 16; k++) begin
        drive(1'b1, 4'(k), 1'b0, 1'b0, 4'h0, 1'b0);
        n_total++;
        if (id_exec !== exp_pass(4'(k), 4'(s))) begin
          n_bad++;
          $display("FAIL dec s=%h cond=%h got=%b exp=%b", s, k, id_exec, exp_pass(4'(k), 4'(s)));
        end
      end
    end
  endtask

  task automatic test_hazard();
    do_reset();
    drive(1'b1, 4'h0, 1'b0, 1'b1, 4'b0001, 1'b0);
    n_total++; if (id_stall !== 1'b1 || id_exec !== 1'b0) begin n_bad++; $display("FAIL haz_c1 got=stall%b/exec%b exp=1/0", id_stall, id_exec); end
    tick();
    // ex_flags_we stays high: an exec now proves the hazard check is off in HAZ.
    n_total++; if (status_q !== 4'b0001) begin n_bad++; $display("FAIL haz_status got=%b exp=0001", status_q); end
    n_total++; if (id_exec !== 1'b1 || id_stall !== 1'b0) begin n_bad++; $display("FAIL haz_c2 got=exec%b/stall%b exp=1/0", id_exec, id_stall); end
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    n_total++; if (stall_cnt !== 3'd1) begin n_bad++; $display("FAIL haz_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_branch();
    do_reset();
    drive(1'b1, 4'he, 1'b1, 1'b0, 4'h0, 1'b0);
    n_total++; if (id_exec !== 1'b1 || flush !== 1'b0) begin n_bad++; $display("FAIL br_issue got=exec%b/flush%b exp=1/0", id_exec, flush); end
    tick();
    drive(1'b1, 4'he, 1'b0, 1'b0, 4'h0, 1'b0);
    n_total++; if (flush !== 1'b1 || id_exec !== 1'b0) begin n_bad++; $display("FAIL br_f1 got=flush%b/exec%b exp=1/0", flush, id_exec); end
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    n_total++; if (flush !== 1'b1) begin n_bad++; $display("FAIL br_f2 got=%b exp=1", flush); end
    tick();
    n_total++; if (flush !== 1'b0) begin n_bad++; $display("FAIL br_end got=%b exp=0", flush); end
    n_total++; if (flush_cnt !== 3'd1) begin n_bad++; $display("FAIL br_cnt got=%0d exp=1", flush_cnt); end
  endtask

  task automatic test_haz_branch();
    do_reset();
    drive(1'b1, 4'h0, 1'b1, 1'b1, 4'b0001, 1'b0);
    n_total++; if (id_stall !== 1'b1 || id_exec !== 1'b0) begin n_bad++; $display("FAIL hb_stall got=stall%b/exec%b exp=1/0", id_stall, id_exec); end
    tick();
    drive(1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);
    n_total++; if (id_exec !== 1'b1 || id_stall !== 1'b0 || flush !== 1'b0) begin n_bad++; $display("FAIL hb_take got=exec%b/stall%b/flush%b exp=1/0/0", id_exec, id_stall, flush); end
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    n_total++; if (flush !== 1'b1) begin n_bad++; $display("FAIL hb_f1 got=%b exp=1", flush); end
    tick();
    n_total++; if (flush !== 1'b1) begin n_bad++; $display("FAIL hb_f2 got=%b exp=1", flush); end
    tick();
    n_total++; if (flush !== 1'b0) begin n_bad++; $display("FAIL hb_end got=%b exp=0", flush); end
    n_total++; if (stall_cnt !== 3'd1 || flush_cnt !== 3'd1) begin n_bad++; $display("FAIL hb_cnt got=%0d/%0d exp=1/1", stall_cnt, flush_cnt); end
  endtask

  task automatic test_freeze_run();
    do_reset();
    drive(1'b1, 4'h0, 1'b0, 1'b1, 4'b0101, 1'b1);
    n_total++; if (id_stall !== 1'b0 || id_exec !== 1'b0) begin n_bad++; $display("FAIL frz_run got=stall%b/exec%b exp=0/0", id_stall, id_exec); end
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    n_total++; if (status_q !== 4'b0000 || stall_cnt !== 3'd0) begin n_bad++; $display("FAIL frz_run_hold got=%b/%0d exp=0000/0", status_q, stall_cnt); end
  endtask

  task automatic test_freeze_flush();
    do_reset();
    drive(1'b1, 4'he, 1'b1, 1'b0, 4'h0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    n_total++; if (flush !== 1'b1) begin n_bad++; $display("FAIL ff_f1 got=%b exp=1", flush); end
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_total++; if (flush !== 1'b1) begin n_bad++; $display("FAIL ff_frozen%0d got=%b exp=1", i, flush); end
      tick();
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    n_total++; if (flush !== 1'b1) begin n_bad++; $display("FAIL ff_last got=%b exp=1", flush); end
    n_total++; if (status_q !== 4'b0000) begin n_bad++; $display("FAIL ff_status got=%b exp=0000", status_q); end
    tick();
    n_total++; if (flush !== 1'b0 || flush_cnt !== 3'd1) begin n_bad++; $display("FAIL ff_end got=flush%b/cnt%0d exp=0/1", flush, flush_cnt); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 4'b1010, 1'b0);
    tick();
    drive(1'b1, 4'he, 1'b1, 1'b0, 4'h0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    n_total++; if (flush !== 1'b1 || flush_cnt !== 3'd1) begin n_bad++; $display("FAIL rmf_pre got=flush%b/cnt%0d exp=1/1", flush, flush_cnt); end
    #2;
    rst = 1'b0;
    #1;
    n_total++; if (flush !== 1'b0) begin n_bad++; $display("FAIL rmf_flush got=%b exp=0", flush); end
    tick();
    rst = 1'b1;
    tick();
    n_total++; if (flush !== 1'b0) begin n_bad++; $display("FAIL rmf_residual got=%b exp=0", flush); end
    n_total++; if (status_q !== 4'b0000 || stall_cnt !== 3'd0 || flush_cnt !== 3'd0) begin n_bad++; $display("FAIL rmf_regs got=%b/%0d/%0d exp=0000/0/0", status_q, stall_cnt, flush_cnt); end
    drive(1'b1, 4'he, 1'b1, 1'b0, 4'h0, 1'b0);
    n_total++; if (id_exec !== 1'b1) begin n_bad++; $display("FAIL rmf_run got=%b exp=1", id_exec); end
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    n_total++; if (flush !== 1'b1) begin n_bad++; $display("FAIL rmf_rebranch got=%b exp=1", flush); end
    tick();
    tick();
  endtask

  task automatic test_untaken();
    do_reset();
    drive(1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);
    n_total++; if (id_exec !== 1'b0 || id_stall !== 1'b0) begin n_bad++; $display("FAIL nt_issue got=exec%b/stall%b exp=0/0", id_exec, id_stall); end
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    n_total++; if (flush !== 1'b0 || flush_cnt !== 3'd0) begin n_bad++; $display("FAIL nt_noflush got=%b/%0d exp=0/0", flush, flush_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    // RUN(stall) / HAZ(exec) alternate, so one stall every two cycles.
    drive(1'b1, 4'h0, 1'b0, 1'b1, 4'b0001, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    n_total++; if (stall_cnt !== 3'd3) begin n_bad++; $display("FAIL sat_stall_mid got=%0d exp=3", stall_cnt); end
    for (int i = 0; i < 14; i++) tick();
    n_total++; if (stall_cnt !== 3'd7) begin n_bad++; $display("FAIL sat_stall got=%0d exp=7", stall_cnt); end
    do_reset();
    // One taken branch every three cycles with a two-cycle flush.
    drive(1'b1, 4'he, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 30; i++) tick();
    n_total++; if (flush_cnt !== 3'd7) begin n_bad++; $display("FAIL sat_flush got=%0d exp=7", flush_cnt); end
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    #5;
    test_reset();
    test_decode();
    test_hazard();
    test_branch();
    test_haz_branch();
    test_freeze_run();
    test_freeze_flush();
    test_reset_mid_flush();
    test_untaken();
    test_saturation();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
